regwb_arb: RTL and testbench

- Write-back arbiter and buffer that drives the single write port of the 32x32 register file (write, wrreg, wrdata).
- Merges two result sources:
  - the single-cycle ALU path, which always wins and has no backpressure;
  - the long-latency unit path (loads, mul/div), which uses a valid/ready handshake and a small FIFO.
- Suppresses writes to register 0.
- Keeps a pending-destination bitmap so decode can stall on RAW/WAW hazards against in-flight long-latency ops.

---
 rtl/regwb_pkg.sv | 14 +
 rtl/regwb_arb_fifo.sv | 56 +++++
 rtl/regwb_arb.sv | 119 +++++++++++
 tb/tb_regwb_arb.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/regwb_pkg.sv
// Shared types and constants for the register-file write-back path.
package regwb_pkg;

    localparam logic [4:0] REG_ZERO = 5'd0;
    localparam int         DW       = 32;
    localparam int         AW       = 5;
    localparam int         NREGS    = 32;

    typedef struct packed {
        logic [AW-1:0] idx;
        logic [DW-1:0] data;
    } wb_req_t;

endpackage

// File: rtl/regwb_arb_fifo.sv
// DEPTH-entry synchronous FIFO of write-back requests; head is valid whenever !empty.
// Caller must not push when full or pop when empty; push and pop may share a cycle.
module wb_fifo
    import regwb_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PW = $clog2(DEPTH),
    localparam int LW = PW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  wb_req_t       push_dat,
    input  logic          pop,
    output logic          full,
    output logic          empty,
    output logic [LW-1:0] level,
    output wb_req_t       head
);

    wb_req_t       mem_q [DEPTH];
    logic [PW-1:0] wptr_q, wptr_d;
    logic [PW-1:0] rptr_q, rptr_d;
    logic [LW-1:0] level_q, level_d;

    assign full  = (level_q == LW'(DEPTH));
    assign empty = (level_q == '0);
    assign level = level_q;
    assign head  = mem_q[rptr_q];

    // DEPTH is a power of two, so pointer increments wrap on their own.
    always_comb begin
        wptr_d  = push ? wptr_q + 1'b1 : wptr_q;
        rptr_d  = pop  ? rptr_q + 1'b1 : rptr_q;
        level_d = level_q + LW'(push) - LW'(pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            level_q <= level_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wptr_q] <= push_dat;
        end
    end

endmodule

// File: rtl/regwb_arb.sv
// Write-back arbiter: ALU always wins, long-unit results queue or bypass; r0 writes dropped.
// Registered write port (1 cycle); lu_ready = FIFO not full, no look-ahead on same-cycle pop.
module regwb_arb
    import regwb_pkg::*;
#(
    parameter int DW    = 32,
    parameter int AW    = 5,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   alu_valid,
    input  logic [AW-1:0]          alu_reg,
    input  logic [DW-1:0]          alu_data,
    input  logic                   lu_valid,
    output logic                   lu_ready,
    input  logic [AW-1:0]          lu_reg,
    input  logic [DW-1:0]          lu_data,
    input  logic                   iss_valid,
    input  logic [AW-1:0]          iss_reg,
    output logic                   write,
    output logic [AW-1:0]          wrreg,
    output logic [DW-1:0]          wrdata,
    output logic [NREGS-1:0]       pending,
    output logic [$clog2(DEPTH):0] fifo_level
);

    logic          fifo_full, fifo_empty;
    logic          fifo_push, fifo_pop;
    wb_req_t       fifo_head;
    wb_req_t       lu_req;

    logic          aluq;
    logic          lu_take;
    logic          lu_commit;

    logic             write_q,   write_d;
    logic [AW-1:0]    wrreg_q,   wrreg_d;
    logic [DW-1:0]    wrdata_q,  wrdata_d;
    logic [NREGS-1:0] pending_q, pending_d;

    assign lu_ready = !fifo_full;
    assign aluq     = alu_valid && (alu_reg != REG_ZERO);
    // An accepted r0 result completes its handshake but is never stored or written.
    assign lu_take  = lu_valid && lu_ready && (lu_reg != REG_ZERO);
    assign lu_req   = '{idx: lu_reg, data: lu_data};

    always_comb begin
        write_d   = 1'b0;
        wrreg_d   = wrreg_q;
        wrdata_d  = wrdata_q;
        fifo_push = 1'b0;
        fifo_pop  = 1'b0;
        lu_commit = 1'b0;
        if (aluq) begin
            write_d   = 1'b1;
            wrreg_d   = alu_reg;
            wrdata_d  = alu_data;
            fifo_push = lu_take;
        end else if (!fifo_empty) begin
            write_d   = 1'b1;
            wrreg_d   = fifo_head.idx;
            wrdata_d  = fifo_head.data;
            fifo_pop  = 1'b1;
            fifo_push = lu_take;
            lu_commit = 1'b1;
        end else if (lu_take) begin
            write_d   = 1'b1;
            wrreg_d   = lu_reg;
            wrdata_d  = lu_data;
            lu_commit = 1'b1;
        end
    end

    // Clear first so a same-cycle issue to the committing register keeps its bit.
    always_comb begin
        pending_d = pending_q;
        if (lu_commit) begin
            pending_d[wrreg_d] = 1'b0;
        end
        if (iss_valid && (iss_reg != REG_ZERO)) begin
            pending_d[iss_reg] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            write_q   <= 1'b0;
            wrreg_q   <= '0;
            wrdata_q  <= '0;
            pending_q <= '0;
        end else begin
            write_q   <= write_d;
            wrreg_q   <= wrreg_d;
            wrdata_q  <= wrdata_d;
            pending_q <= pending_d;
        end
    end

    wb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (fifo_push),
        .push_dat (lu_req),
        .pop      (fifo_pop),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .level    (fifo_level),
        .head     (fifo_head)
    );

    assign write   = write_q;
    assign wrreg   = wrreg_q;
    assign wrdata  = wrdata_q;
    assign pending = pending_q;

endmodule

// File: tb/tb_regwb_arb.sv
// Directed scenarios plus random traffic checked against a queue-based model.
module tb_regwb_arb;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        alu_valid = 1'b0;
    logic [4:0]  alu_reg = '0;
    logic [31:0] alu_data = '0;
    logic        lu_valid = 1'b0;
    logic        lu_ready;
    logic [4:0]  lu_reg = '0;
    logic [31:0] lu_data = '0;
    logic        iss_valid = 1'b0;
    logic [4:0]  iss_reg = '0;
    logic        write;
    logic [4:0]  wrreg;
    logic [31:0] wrdata;
    logic [31:0] pending;
    logic [2:0]  fifo_level;

    int total = 0;
    int bad   = 0;

    regwb_arb #(.DW(32), .AW(5), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .alu_valid  (alu_valid),
        .alu_reg    (alu_reg),
        .alu_data   (alu_data),
        .lu_valid   (lu_valid),
        .lu_ready   (lu_ready),
        .lu_reg     (lu_reg),
        .lu_data    (lu_data),
        .iss_valid  (iss_valid),
        .iss_reg    (iss_reg),
        .write      (write),
        .wrreg      (wrreg),
        .wrdata     (wrdata),
        .pending    (pending),
        .fifo_level (fifo_level)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: a queue of waiting results plus a bitmap of outstanding registers.
    typedef struct {
        logic [4:0]  r;
        logic [31:0] d;
    } ent_t;

    ent_t        mq[$];
    logic        m_write = 1'b0;
    logic [4:0]  m_reg   = '0;
    logic [31:0] m_data  = '0;
    logic [31:0] m_pend  = '0;

    always @(posedge clk or negedge rst_n) begin
        ent_t e;
        bit   acc;
        bit   lu_wr;
        if (!rst_n) begin
            mq.delete();
            m_write = 1'b0;
            m_reg   = '0;
            m_data  = '0;
            m_pend  = '0;
        end else begin
            acc   = lu_valid && (mq.size() < DEPTH) && (lu_reg != 0);
            lu_wr = 1'b0;
            e.r   = lu_reg;
            e.d   = lu_data;
            if (alu_valid && alu_reg != 0) begin
                m_write = 1'b1;
                m_reg   = alu_reg;
                m_data  = alu_data;
                if (acc) mq.push_back(e);
            end else if (mq.size() > 0) begin
                ent_t h;
                h       = mq.pop_front();
                m_write = 1'b1;
                m_reg   = h.r;
                m_data  = h.d;
                lu_wr   = 1'b1;
                if (acc) mq.push_back(e);
            end else if (acc) begin
                m_write = 1'b1;
                m_reg   = lu_reg;
                m_data  = lu_data;
                lu_wr   = 1'b1;
            end else begin
                m_write = 1'b0;
            end
            if (lu_wr) m_pend[m_reg] = 1'b0;
            if (iss_valid && iss_reg != 0) m_pend[iss_reg] = 1'b1;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("m_write",    write,      m_write);
            chk("m_wrreg",    wrreg,      m_reg);
            chk("m_wrdata",   wrdata,     m_data);
            chk("m_pending",  pending,    m_pend);
            chk("m_level",    fifo_level, mq.size());
            chk("m_lu_ready", lu_ready,   mq.size() < DEPTH);
        end
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        alu_valid = 1'b0;
        lu_valid  = 1'b0;
        iss_valid = 1'b0;
    endtask

    initial begin
        int  k;
        bit  r;

        #1;
        chk("rst_write", write, 0);
        chk("rst_pending", pending, 0);
        chk("rst_level", fifo_level, 0);
        chk("rst_ready", lu_ready, 1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        tick();

        // ALU write and its one-cycle pulse
        alu_valid = 1; alu_reg = 5; alu_data = 32'hDEADBEEF;
        tick();
        chk("t1_write", write, 1);
        chk("t1_reg", wrreg, 5);
        chk("t1_data", wrdata, 32'hDEADBEEF);
        idle();
        tick();
        chk("t1_write_off", write, 0);
        chk("t1_reg_hold", wrreg, 5);

        // Issue then bypass
        iss_valid = 1; iss_reg = 9;
        tick();
        chk("t2_pend_set", pending[9], 1);
        idle();
        lu_valid = 1; lu_reg = 9; lu_data = 32'h1234;
        tick();
        chk("t2_write", write, 1);
        chk("t2_reg", wrreg, 9);
        chk("t2_data", wrdata, 32'h1234);
        chk("t2_pend_clr", pending[9], 0);
        chk("t2_level", fifo_level, 0);
        idle();

        // FIFO fill under ALU pressure, then in-order drain
        k = 1;
        alu_valid = 1; alu_reg = 20; alu_data = 32'hA0A0;
        lu_valid = 1; lu_reg = 5'(k); lu_data = 32'h100 + k;
        for (int c = 0; c < 6; c++) begin
            r = lu_ready;
            tick();
            if (r) k++;
            lu_reg = 5'(k); lu_data = 32'h100 + k;
        end
        chk("t3_level_full", fifo_level, 4);
        chk("t3_ready_low", lu_ready, 0);
        chk("t3_accepts", k, 5);
        alu_valid = 0;
        for (int w = 1; w <= 6; w++) begin
            r = lu_ready;
            tick();
            if (r && k <= 6) k++;
            lu_reg = 5'(k); lu_data = 32'h100 + k;
            if (k > 6) lu_valid = 0;
            chk("t3_drain_write", write, 1);
            chk("t3_drain_reg", wrreg, w);
            chk("t3_drain_data", wrdata, 32'h100 + w);
        end
        idle();
        tick();

        // r0 filtering on both sources
        alu_valid = 1; alu_reg = 0; alu_data = 32'h5555;
        lu_valid = 1; lu_reg = 7; lu_data = 32'h77;
        tick();
        chk("t4_reg", wrreg, 7);
        chk("t4_data", wrdata, 32'h77);
        idle();
        lu_valid = 1; lu_reg = 0; lu_data = 32'h99;
        tick();
        chk("t4_r0_nowrite", write, 0);
        chk("t4_r0_level", fifo_level, 0);
        idle();

        // Set wins over same-cycle clear
        iss_valid = 1; iss_reg = 3;
        tick();
        idle();
        alu_valid = 1; alu_reg = 10; alu_data = 32'h10;
        lu_valid = 1; lu_reg = 3; lu_data = 32'h33;
        tick();
        chk("t5_level", fifo_level, 1);
        idle();
        iss_valid = 1; iss_reg = 3;
        tick();
        chk("t5_write", write, 1);
        chk("t5_reg", wrreg, 3);
        chk("t5_pend_kept", pending[3], 1);
        idle();
        lu_valid = 1; lu_reg = 3; lu_data = 32'h34;
        tick();
        idle();

        // Asynchronous reset with queued work
        for (int i = 4; i <= 7; i++) begin
            iss_valid = 1; iss_reg = 5'(i);
            tick();
        end
        idle();
        alu_valid = 1; alu_reg = 11; alu_data = 32'hB;
        lu_valid = 1;
        for (int i = 12; i <= 14; i++) begin
            lu_reg = 5'(i); lu_data = 32'(i);
            tick();
        end
        idle();
        chk("t6_pend", pending, 32'h0000_00F0);
        chk("t6_level", fifo_level, 3);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_write", write, 0);
        chk("t6_reg", wrreg, 0);
        chk("t6_data", wrdata, 0);
        chk("t6_pend0", pending, 0);
        chk("t6_level0", fifo_level, 0);
        chk("t6_ready", lu_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t6_no_stale", write, 0);
        end

        // Random traffic
        for (int c = 0; c < 3000; c++) begin
            alu_valid = ($urandom_range(0, 99) < 40);
            alu_reg   = 5'($urandom_range(0, 31));
            alu_data  = $urandom;
            lu_valid  = ($urandom_range(0, 99) < 55);
            lu_reg    = 5'($urandom_range(0, 31));
            lu_data   = $urandom;
            iss_valid = ($urandom_range(0, 99) < 30);
            iss_reg   = 5'($urandom_range(0, 31));
            tick();
        end
        idle();
        repeat (8) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
